// File: rtl/instr_queue_pkg.sv
// Shared types and width helpers for the instruction queue.
//
// Optional feature macro: INSTR_QUEUE_CHECKSUM_EN (trailing XOR checksum byte per frame).
package instr_queue_pkg;

    // Host-side frame assembler states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_STB = 2'd1,
        ACK      = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    // Default parameter values shared by the block and its users.
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_INSTR_BYTES = 4;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Bits needed to hold a byte count in 0..instr_bytes.
    function automatic int len_width(input int instr_bytes);
        return $clog2(instr_bytes + 1);
    endfunction

    // Bits needed to hold a FIFO occupancy in 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // One FIFO entry: packed payload bytes plus their count.
    function automatic int entry_width(input int data_w, input int instr_bytes);
        return data_w * instr_bytes + len_width(instr_bytes);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-around pointers.
// A push is accepted while full only when a pop happens in the same cycle.
// The head output reads as zero while the FIFO is empty.
module instr_fifo
    import instr_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_push,
    input  logic [WIDTH-1:0]                 i_data,
    input  logic                             i_pop,
    output logic [WIDTH-1:0]                 o_data,
    output logic                             o_valid,
    output logic                             o_full,
    output logic [$clog2(DEPTH+1)-1:0]       o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign o_full  = (count == FULL_CNT);
    assign o_valid = !empty;
    assign o_count = count;
    assign pop_ok  = i_pop && !empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    // Storage write; contents are only meaningful between push and pop.
    // NOTE: the storage array has no reset on purpose -- occupancy is tracked by
    // the pointers and count, so resetting every entry would only add logic.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head presentation: zero when nothing is queued.
    always_comb begin
        o_data = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: rtl/instruction_queue.sv
// Host byte-stream instruction assembler feeding a FIFO drained by the command decoder.
// Host side: active-low frame/strobe with four-phase ack; consumer side: valid/ready.
// Optional feature macro: INSTR_QUEUE_CHECKSUM_EN -- last byte of each frame is an XOR
// checksum of the preceding bytes; it is not stored, and a mismatching frame is dropped.
module instruction_queue
    import instr_queue_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_frame_n,
    input  logic                                i_strobe_n,
    input  logic [DATA_W-1:0]                   i_data,
    output logic                                o_ack,
    output logic [DATA_W*INSTR_BYTES-1:0]       o_instr,
    output logic [$clog2(INSTR_BYTES+1)-1:0]    o_len,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic                                o_full,
    output logic [$clog2(DEPTH+1)-1:0]          o_count,
    output logic                                o_err
);

    localparam int PAYLOAD_W = DATA_W * INSTR_BYTES;
    localparam int LEN_W     = len_width(INSTR_BYTES);
    localparam int ENTRY_W   = entry_width(DATA_W, INSTR_BYTES);
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(INSTR_BYTES);

    // ---------------- input synchronisers ----------------
    logic [SYNC_STAGES-1:0] frame_sync;
    logic [SYNC_STAGES-1:0] strobe_sync;
    logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
    logic                   s_frame_n;
    logic                   s_strobe_n;
    logic [DATA_W-1:0]      s_data;

    // Shift host pins through the synchroniser chains; control lines idle high.
    // NOTE: every clocked register uses non-blocking assignment so all stages sample
    // the pre-edge value of their predecessor, which is what makes this a shift chain.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            frame_sync  <= '1;
            strobe_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
        end else begin
            frame_sync  <= {frame_sync[SYNC_STAGES-2:0], i_frame_n};
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], i_strobe_n};
            data_sync[0] <= i_data;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
        end
    end

    assign s_frame_n  = frame_sync[SYNC_STAGES-1];
    assign s_strobe_n = strobe_sync[SYNC_STAGES-1];
    assign s_data     = data_sync[SYNC_STAGES-1];

    // ---------------- assembly datapath ----------------
    state_t             state_q;
    state_t             state_d;
    logic [PAYLOAD_W-1:0] asm_q;
    logic [LEN_W-1:0]   byte_cnt;
    logic               overrun_q;
    logic               clear_asm;
    logic               take_byte;
    logic               store_en;
    logic [DATA_W-1:0]  store_byte;
    logic               cks_ok;
    logic               asm_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_space;
    logic               fifo_full;

`ifdef INSTR_QUEUE_CHECKSUM_EN
    // The newest byte is held back: it becomes payload only once another byte follows,
    // so the one left here when the frame closes is the checksum.
    logic [DATA_W-1:0] last_q;
    logic [DATA_W-1:0] xor_q;
    logic              have_last_q;

    assign store_en   = have_last_q;
    assign store_byte = last_q;
    assign cks_ok     = (xor_q == '0);
`else
    assign store_en   = 1'b1;
    assign store_byte = s_data;
    assign cks_ok     = 1'b1;
`endif

    assign asm_empty = (byte_cnt == '0);

    // Collect bytes into the assembly register; bytes beyond capacity only flag overrun.
    always_ff @(posedge i_clk) begin
        if (i_reset || clear_asm) begin
            asm_q     <= '0;
            byte_cnt  <= '0;
            overrun_q <= 1'b0;
`ifdef INSTR_QUEUE_CHECKSUM_EN
            last_q      <= '0;
            xor_q       <= '0;
            have_last_q <= 1'b0;
`endif
        end else if (take_byte) begin
            if (store_en) begin
                if (byte_cnt < MAX_CNT) begin
                    asm_q[int'(byte_cnt)*DATA_W +: DATA_W] <= store_byte;
                    byte_cnt <= byte_cnt + LEN_W'(1);
                end else begin
                    overrun_q <= 1'b1;
                end
            end
`ifdef INSTR_QUEUE_CHECKSUM_EN
            last_q      <= s_data;
            xor_q       <= xor_q ^ s_data;
            have_last_q <= 1'b1;
`endif
        end
    end

    // ---------------- frame FSM ----------------
    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: one byte per strobe, commit on frame release.
    // NOTE: state_d gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!s_frame_n) state_d = WAIT_STB;
            WAIT_STB: begin
                if (!s_strobe_n)     state_d = ACK;
                else if (s_frame_n)  state_d = COMMIT;
            end
            ACK:      if (s_strobe_n) state_d = WAIT_STB;
            COMMIT:   if (asm_empty || !cks_ok || fifo_space) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output and datapath-control decode from the current state.
    always_comb begin
        o_ack     = (state_q == ACK);
        clear_asm = (state_q == IDLE);
        take_byte = (state_q == WAIT_STB) && !s_strobe_n;
        fifo_push = (state_q == COMMIT) && !asm_empty && cks_ok && fifo_space;
        o_err     = (state_q == COMMIT) && !asm_empty &&
                    (!cks_ok || (fifo_space && overrun_q));
    end

    // ---------------- FIFO ----------------
    logic [ENTRY_W-1:0] fifo_head;

    // A pop this cycle frees a slot, so a full FIFO can still take the pending entry.
    assign fifo_pop   = o_valid && i_ready;
    assign fifo_space = !fifo_full || fifo_pop;

    instr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (fifo_push),
        .i_data  ({byte_cnt, asm_q}),
        .i_pop   (fifo_pop),
        .o_data  (fifo_head),
        .o_valid (o_valid),
        .o_full  (fifo_full),
        .o_count (o_count)
    );

    assign o_full  = fifo_full;
    assign o_instr = fifo_head[PAYLOAD_W-1:0];
    assign o_len   = fifo_head[ENTRY_W-1 -: LEN_W];

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue (default build, checksum feature off).
module tb_instruction_queue;

    localparam int DATA_W      = 8;
    localparam int INSTR_BYTES = 4;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic        i_clk;
    logic        i_reset;
    logic        i_frame_n;
    logic        i_strobe_n;
    logic [7:0]  i_data;
    logic        o_ack;
    logic [31:0] o_instr;
    logic [2:0]  o_len;
    logic        o_valid;
    logic        i_ready;
    logic        o_full;
    logic [2:0]  o_count;
    logic        o_err;

    instruction_queue #(
        .DATA_W      (DATA_W),
        .INSTR_BYTES (INSTR_BYTES),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_frame_n  (i_frame_n),
        .i_strobe_n (i_strobe_n),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_instr    (o_instr),
        .o_len      (o_len),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_full     (o_full),
        .o_count    (o_count),
        .o_err      (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- bookkeeping and reference model ----------------
    typedef struct {
        logic [31:0] instr;
        int          len;
    } entry_t;

    entry_t model_q[$];
    int     n_checks  = 0;
    int     n_errors  = 0;
    int     exp_err   = 0;
    int     obs_err   = 0;
    int     exp_acks  = 0;
    int     obs_acks  = 0;
    logic   ack_prev  = 1'b0;
    bit     rand_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Host-level model of one completed frame: first INSTR_BYTES bytes kept, rest flagged.
    function automatic void model_frame(input logic [7:0] b[$]);
        entry_t e;
        int     n = b.size();
        int     keep = (n > INSTR_BYTES) ? INSTR_BYTES : n;
        exp_acks += n;
        if (n > INSTR_BYTES) exp_err++;
        if (n > 0) begin
            e.instr = '0;
            for (int k = 0; k < keep; k++) e.instr[8*k +: 8] = b[k];
            e.len = keep;
            model_q.push_back(e);
        end
    endfunction

    // Monitor on the falling edge: count acks/errors, score every pop against the model.
    always @(negedge i_clk) begin
        if (o_ack === 1'b1 && ack_prev === 1'b0) obs_acks++;
        ack_prev = o_ack;
        if (!i_reset) begin
            if (o_err === 1'b1) obs_err++;
            if (o_valid === 1'b1 && i_ready === 1'b1) begin
                if (model_q.size() == 0) begin
                    check("pop_with_model_empty", 64'(o_valid), 64'd0);
                end else begin
                    entry_t e;
                    e = model_q.pop_front();
                    check("pop_instr", 64'(o_instr), 64'(e.instr));
                    check("pop_len", 64'(o_len), 64'(e.len));
                end
            end else if (o_valid === 1'b0) begin
                check("empty_head_zero", {29'd0, o_len, o_instr}, 64'd0);
            end
        end
    end

    // ---------------- host driver ----------------
    // Advance to the drive point just after the next rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    // Wait (bounded) until o_ack reaches lvl; returns edges elapsed.
    task automatic wait_ack(input logic lvl, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < 300) begin
            @(posedge i_clk);
            cycles++;
            @(negedge i_clk);
            if (o_ack === lvl) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge i_clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit check_lat);
        int cyc;
        bit ok;
        i_data     = b;
        i_strobe_n = 1'b0;
        wait_ack(1'b1, cyc, ok);
        if (!ok) check("ack_rise_timeout", 64'd0, 64'd1);
        else if (check_lat) check("ack_latency", 64'(cyc), 64'(SYNC_STAGES + 1));
        i_strobe_n = 1'b1;
        wait_ack(1'b0, cyc, ok);
        if (!ok) check("ack_fall_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input logic [7:0] b[$], input bit check_lat, input bit check_commit);
        i_frame_n = 1'b0;
        tick(3);
        foreach (b[k]) send_byte(b[k], check_lat);
        i_frame_n = 1'b1;
        model_frame(b);
        if (check_commit) begin
            bit seen = 1'b0;
            for (int c = 0; c < SYNC_STAGES + 2; c++) begin
                @(posedge i_clk);
                @(negedge i_clk);
                if (o_valid === 1'b1) seen = 1'b1;
            end
            check("commit_latency", 64'(seen), 64'd1);
        end
        tick(SYNC_STAGES + 4);
    endtask

    function automatic void rand_frame(output logic [7:0] b[$], input int min_len, input int max_len);
        int n = $urandom_range(max_len, min_len);
        b = {};
        for (int k = 0; k < n; k++) b.push_back(8'($urandom));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] fr[$];
        int cyc;
        bit ok;

        i_reset    = 1'b1;
        i_frame_n  = 1'b1;
        i_strobe_n = 1'b1;
        i_data     = '0;
        i_ready    = 1'b0;
        tick(3);
        i_reset = 1'b0;
        tick(1);

        // Reset state.
        check("rst_ack",   64'(o_ack),   64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_full",  64'(o_full),  64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_err",   64'(o_err),   64'd0);
        check("rst_instr", 64'(o_instr), 64'd0);
        check("rst_len",   64'(o_len),   64'd0);

        // Four-byte frame, latencies checked.
        send_frame('{8'h12, 8'h34, 8'h56, 8'h78}, 1'b1, 1'b1);
        check("f1_valid", 64'(o_valid), 64'd1);
        check("f1_instr", 64'(o_instr), 64'h7856_3412);
        check("f1_len",   64'(o_len),   64'd4);
        check("f1_acks",  64'(obs_acks), 64'd4);
        check("f1_err",   64'(obs_err),  64'd0);

        // Two-byte frame, then an empty frame that must not push.
        send_frame('{8'hA1, 8'h05}, 1'b1, 1'b0);
        check("f2_count", 64'(o_count), 64'd2);
        send_frame('{}, 1'b0, 1'b0);
        check("empty_frame_count", 64'(o_count), 64'd2);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        check("f2_instr", 64'(o_instr), 64'h0000_05A1);
        check("f2_len",   64'(o_len),   64'd2);

        // Overrun: six bytes into a four-byte instruction.
        send_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1'b1, 1'b0);
        check("ovr_err_pulses", 64'(obs_err),  64'd1);
        check("ovr_acks",       64'(obs_acks), 64'd12);
        check("ovr_count",      64'(o_count),  64'd2);
        i_ready = 1'b1;
        tick(4);
        i_ready = 1'b0;
        check("ovr_drained", 64'(o_count), 64'd0);

        // Fill the FIFO, then back-pressure the host.
        for (int f = 0; f < DEPTH; f++) begin
            rand_frame(fr, 1, INSTR_BYTES);
            send_frame(fr, 1'b1, 1'b0);
            if (f == DEPTH - 2) check("not_full_yet", 64'(o_full), 64'd0);
        end
        check("full_after_depth", 64'(o_full),  64'd1);
        check("count_at_depth",   64'(o_count), 64'd4);
        rand_frame(fr, 1, INSTR_BYTES);
        send_frame(fr, 1'b1, 1'b0);           // assembled, parked awaiting space
        tick(10);
        check("fifth_parked_count", 64'(o_count), 64'd4);

        // Sixth frame's first byte must stall while the fifth waits.
        i_frame_n = 1'b0;
        tick(3);
        i_data     = 8'h66;
        i_strobe_n = 1'b0;
        tick(20);
        check("stalled_no_ack", 64'(o_ack), 64'd0);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        tick(8);
        check("fifth_committed_count", 64'(o_count), 64'd4);
        wait_ack(1'b1, cyc, ok);
        check("sixth_acked", 64'(ok), 64'd1);
        i_strobe_n = 1'b1;
        wait_ack(1'b0, cyc, ok);
        i_frame_n = 1'b1;
        model_frame('{8'h66});
        tick(10);
        check("sixth_parked_full", 64'(o_full), 64'd1);

        // Pop and push on the same edge while full.
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        check("pop_push_same_cycle_count", 64'(o_count), 64'd4);
        i_ready = 1'b1;
        tick(6);
        i_ready = 1'b0;
        check("full_drained_count", 64'(o_count), 64'd0);
        check("full_drained_model", 64'(model_q.size()), 64'd0);

        // Random frames against a randomly stalling consumer.
        fork
            begin
                for (int f = 0; f < 14; f++) begin
                    rand_frame(fr, 0, INSTR_BYTES + 2);
                    send_frame(fr, 1'b0, 1'b0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    i_ready = 1'($urandom_range(1, 0));
                    tick(1);
                end
            end
        join
        i_ready = 1'b1;
        tick(20);
        i_ready = 1'b0;
        check("rand_drained_count", 64'(o_count), 64'd0);
        check("rand_drained_model", 64'(model_q.size()), 64'd0);
        check("rand_err_pulses", 64'(obs_err), 64'(exp_err));

        // Reset in mid-frame with two entries queued.
        send_frame('{8'h11}, 1'b0, 1'b0);
        send_frame('{8'h22, 8'h33}, 1'b0, 1'b0);
        check("pre_reset_count", 64'(o_count), 64'd2);
        i_frame_n = 1'b0;
        tick(3);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        exp_acks += 2;
        i_reset   = 1'b1;
        i_frame_n = 1'b1;
        tick(1);
        check("reset_ack",   64'(o_ack),   64'd0);
        check("reset_count", 64'(o_count), 64'd0);
        check("reset_valid", 64'(o_valid), 64'd0);
        i_reset = 1'b0;
        model_q.delete();
        tick(4);
        send_frame('{8'hDE, 8'hAD, 8'hBE}, 1'b1, 1'b1);
        check("post_reset_instr", 64'(o_instr), 64'h00BE_ADDE);
        check("post_reset_len",   64'(o_len),   64'd3);
        i_ready = 1'b1;
        tick(3);
        i_ready = 1'b0;
        check("final_model_empty", 64'(model_q.size()), 64'd0);
        check("final_acks", 64'(obs_acks), 64'(exp_acks));
        check("final_errs", 64'(obs_err),  64'(exp_err));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
